// File: rtl/obc_dft_pkg.sv
// Shared constants, FSM state type and helpers for the OBC DFT bin sequencer.
package obc_dft_pkg;

    localparam int unsigned N_PTS = 16;
    localparam int unsigned BIN_W = 4;
    localparam int unsigned B     = 8;
    localparam int unsigned BIT_W = 3;
    localparam int unsigned ROM_W = 32;
    localparam int unsigned ACC_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic logic [ACC_W-1:0] sext_rom(input logic [ROM_W-1:0] x);
        return {{(ACC_W-ROM_W){x[ROM_W-1]}}, x};
    endfunction

    // Bit k of every sample gathered into one N_PTS-wide ROM address slice.
    function automatic logic [N_PTS-1:0] slice_of(input logic [N_PTS*B-1:0] s,
                                                  input logic [BIT_W-1:0]   k);
        logic [N_PTS-1:0] r;
        r = '0;
        for (int i = 0; i < N_PTS; i++) begin
            r[i] = s[i*B + int'(k)];
        end
        return r;
    endfunction

endpackage

// File: rtl/obc_da_accumulator.sv
// Bit-serial shift-add accumulator: MSB cycle negates and restarts, bit-0 cycle
// adds the offset term and captures the result.
module obc_da_accumulator
    import obc_dft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             msb_i,
    input  logic             last_i,
    input  logic [ROM_W-1:0] rom_sum_i,
    input  logic [ROM_W-1:0] offset_i,
    output logic [ACC_W-1:0] res_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] res_q, res_d;

    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        if (msb_i) begin
            acc_d = ACC_W'(0) - sext_rom(rom_sum_i);
        end else begin
            acc_d = (acc_q << 1) + sext_rom(rom_sum_i);
        end
        if (last_i) begin
            res_d = acc_d + sext_rom(offset_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            if (en_i) begin
                acc_q <= acc_d;
            end
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/obc_dft_bin_sequencer.sv
// Walks all 16 DFT bins bit-serially through one shared OBC ROM bank and
// streams one complex result per bin.
module obc_dft_bin_sequencer
    import obc_dft_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N_PTS*B-1:0] s_data,
    output logic [N_PTS-1:0]   slice_bits,
    output logic               slice_valid,
    output logic [BIN_W-1:0]   bin_sel,
    input  logic [ROM_W-1:0]   rom_sum_re,
    input  logic [ROM_W-1:0]   rom_sum_im,
    input  logic [ROM_W-1:0]   offset_re,
    input  logic [ROM_W-1:0]   offset_im,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ACC_W-1:0]   m_re,
    output logic [ACC_W-1:0]   m_im,
    output logic [BIN_W-1:0]   m_bin
);

    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(B-1);
    localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(N_PTS-1);

    state_e             state_q, state_d;
    logic [N_PTS*B-1:0] samples_q, samples_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [N_PTS-1:0]   slice_q, slice_d;
    logic               slice_vld_q, slice_vld_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [BIN_W-1:0]   m_bin_q, m_bin_d;
    logic               acc_en, acc_msb, acc_last;

    always_comb begin
        state_d     = state_q;
        samples_d   = samples_q;
        bin_d       = bin_q;
        bit_d       = bit_q;
        slice_d     = slice_q;
        slice_vld_d = slice_vld_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_bin_d     = m_bin_q;
        acc_en      = 1'b0;
        acc_msb     = 1'b0;
        acc_last    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready_q) begin
                    samples_d   = s_data;
                    bin_d       = '0;
                    bit_d       = BIT_MSB;
                    slice_d     = slice_of(s_data, BIT_MSB);
                    slice_vld_d = 1'b1;
                    s_ready_d   = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_en  = 1'b1;
                acc_msb = (bit_q == BIT_MSB);
                if (bit_q == '0) begin
                    acc_last    = 1'b1;
                    slice_d     = '0;
                    slice_vld_d = 1'b0;
                    m_valid_d   = 1'b1;
                    m_bin_d     = bin_q;
                    state_d     = ST_OUT;
                end else begin
                    bit_d   = bit_q - BIT_W'(1);
                    slice_d = slice_of(samples_q, bit_q - BIT_W'(1));
                end
            end
            ST_OUT: begin
                // Result is held until the consumer takes it; only then move on.
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (bin_q == BIN_MAX) begin
                        s_ready_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bin_d       = bin_q + BIN_W'(1);
                        bit_d       = BIT_MSB;
                        slice_d     = slice_of(samples_q, BIT_MSB);
                        slice_vld_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            samples_q   <= '0;
            bin_q       <= '0;
            bit_q       <= '0;
            slice_q     <= '0;
            slice_vld_q <= 1'b0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_bin_q     <= '0;
        end else begin
            state_q     <= state_d;
            samples_q   <= samples_d;
            bin_q       <= bin_d;
            bit_q       <= bit_d;
            slice_q     <= slice_d;
            slice_vld_q <= slice_vld_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_bin_q     <= m_bin_d;
        end
    end

    obc_da_accumulator u_acc_re (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (acc_en),
        .msb_i     (acc_msb),
        .last_i    (acc_last),
        .rom_sum_i (rom_sum_re),
        .offset_i  (offset_re),
        .res_o     (m_re)
    );

    obc_da_accumulator u_acc_im (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (acc_en),
        .msb_i     (acc_msb),
        .last_i    (acc_last),
        .rom_sum_i (rom_sum_im),
        .offset_i  (offset_im),
        .res_o     (m_im)
    );

    assign s_ready     = s_ready_q;
    assign slice_bits  = slice_q;
    assign slice_valid = slice_vld_q;
    assign bin_sel     = bin_q;
    assign m_valid     = m_valid_q;
    assign m_bin       = m_bin_q;

endmodule

// File: tb/tb_obc_dft_bin_sequencer.sv
// Directed bench for obc_dft_bin_sequencer with a toy ROM: re = 100 when
// sample 0's bit is set, im = 0, offset_re = bin index.
module tb_obc_dft_bin_sequencer;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [15:0]  slice_bits;
    logic         slice_valid;
    logic [3:0]   bin_sel;
    logic [31:0]  rom_sum_re;
    logic [31:0]  rom_sum_im;
    logic [31:0]  offset_re;
    logic [31:0]  offset_im;
    logic         m_valid;
    logic         m_ready;
    logic [39:0]  m_re;
    logic [39:0]  m_im;
    logic [3:0]   m_bin;

    int n_checks = 0;
    int n_fail   = 0;

    obc_dft_bin_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .slice_bits  (slice_bits),
        .slice_valid (slice_valid),
        .bin_sel     (bin_sel),
        .rom_sum_re  (rom_sum_re),
        .rom_sum_im  (rom_sum_im),
        .offset_re   (offset_re),
        .offset_im   (offset_im),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_re        (m_re),
        .m_im        (m_im),
        .m_bin       (m_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rom_sum_re = slice_bits[0] ? 32'd100 : 32'd0;
        rom_sum_im = 32'd0;
        offset_re  = {28'd0, bin_sel};
        offset_im  = 32'd0;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sample 0 as a signed 8-bit value times 100, plus bin offset.
    function automatic logic [39:0] exp_re(input logic [127:0] data, input int bin);
        logic [7:0] s0;
        longint     v;
        s0 = data[7:0];
        v  = longint'($signed(s0)) * 100 + longint'(bin);
        return 40'(v);
    endfunction

    task automatic accept_frame(input logic [127:0] data, input bit hold);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = data;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            @(posedge clk);
        end
        check_eq("accept_timeout", 64'(ok), 64'd1);
        #1;
        if (hold) s_data = ~data;
        else      s_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [127:0] data, input bit hold,
                             input int stall_bin, input bit check_lat);
        int cyc;
        int got;
        bit stalled;
        bit done;
        cyc     = 0;
        got     = 0;
        stalled = 1'b0;
        done    = 1'b0;
        accept_frame(data, hold);
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge clk);
            cyc++;
            if (stall_bin >= 0 && !stalled && slice_valid && int'(bin_sel) == stall_bin) begin
                m_ready = 1'b0;
                for (int w = 0; w < 20 && !m_valid; w++) @(negedge clk);
                check_eq("stall_valid", 64'(m_valid), 64'd1);
                for (int w = 0; w < 5; w++) begin
                    @(negedge clk);
                    check_eq("stall_hold_valid", 64'(m_valid), 64'd1);
                    check_eq("stall_hold_bin", 64'(m_bin), 64'(stall_bin));
                    check_eq("stall_hold_re", 64'(m_re), 64'(exp_re(data, stall_bin)));
                    check_eq("stall_slice_valid", 64'(slice_valid), 64'd0);
                    check_eq("stall_bin_sel", 64'(bin_sel), 64'(stall_bin));
                end
                m_ready = 1'b1;
                stalled = 1'b1;
            end
            if (m_valid && m_ready) begin
                check_eq("res_bin", 64'(m_bin), 64'(got));
                check_eq("res_re", 64'(m_re), 64'(exp_re(data, got)));
                check_eq("res_im", 64'(m_im), 64'd0);
                if (hold) check_eq("s_ready_busy", 64'(s_ready), 64'd0);
                if (check_lat && got == 0) check_eq("first_latency", 64'(cyc), 64'd9);
                got++;
                if (got == 16) s_valid = 1'b0;
            end
            if (got == 16 && s_ready) begin
                if (check_lat) check_eq("s_ready_return", 64'(cyc), 64'd145);
                done = 1'b1;
            end
        end
        check_eq("frame_done", 64'(done), 64'd1);
        check_eq("frame_count", 64'(got), 64'd16);
    endtask

    initial begin
        logic [127:0] d;
        bit           hit;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #12;
        check_eq("rst_s_ready", 64'(s_ready), 64'd1);
        check_eq("rst_slice_valid", 64'(slice_valid), 64'd0);
        check_eq("rst_slice_bits", 64'(slice_bits), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_re", 64'(m_re), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(128'd0, 1'b0, -1, 1'b1);
        run_frame(128'h01, 1'b0, -1, 1'b0);
        d = 128'h80;
        run_frame(d, 1'b0, -1, 1'b0);
        check_eq("msb_bin0_const", 64'(exp_re(d, 0)), 64'h00FF_FFFF_CE00);
        run_frame(128'h01, 1'b0, 3, 1'b0);
        run_frame(128'h80, 1'b1, -1, 1'b0);

        // Asynchronous reset in the middle of bin 7.
        accept_frame(128'h01, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (slice_valid && bin_sel == 4'd7) hit = 1'b1;
        end
        check_eq("reach_bin7", 64'(hit), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_s_ready", 64'(s_ready), 64'd1);
        check_eq("arst_slice_valid", 64'(slice_valid), 64'd0);
        check_eq("arst_bin_sel", 64'(bin_sel), 64'd0);
        check_eq("arst_m_valid", 64'(m_valid), 64'd0);
        check_eq("arst_m_re", 64'(m_re), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_s_ready", 64'(s_ready), 64'd1);
        run_frame(128'h01, 1'b0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
